// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and sizing for the MEM-stage data-memory sequencer.
// The state encoding is intended for reuse by the I-side sequencer.
package dmem_access_ctrl_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } mem_state_e;

  // Memory is word addressed; the byte-select bit is forced to zero.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/ready/rvalid bus between the MEM-stage sequencer (master) and data memory (slave).
interface dmem_access_ctrl_if
  import dmem_access_ctrl_pkg::*;
();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/dmem_access_ctrl_timeout_counter.sv
// Saturation-free wait counter: clear/enable, terminal count flags the last allowed cycle.
module dmem_access_ctrl_timeout_counter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_count;

  // Count cycles spent waiting on the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_en) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_tc = i_en & (r_count == LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: turns EX_MEM load/store controls into a
// req/ready/rvalid transaction and stalls the pipeline until it completes.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_M_MemRead,
  input  logic              i_M_MemWrite,
  input  logic [ADDR_W-1:0] i_M_ALUout,
  input  logic [DATA_W-1:0] i_M_WriteData,
  input  logic              i_pipe_hold,
  dmem_access_ctrl_if.master bus,
  output logic [DATA_W-1:0] o_M_MemData,
  output logic              o_mem_stall,
  output logic              o_mem_err
);

  mem_state_e        r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_err;

  logic w_op;
  logic w_cnt_clr;
  logic w_cnt_en;
  logic w_tc;

  assign w_op      = i_M_MemRead | i_M_MemWrite;
  assign w_cnt_clr = (r_state == ST_IDLE) & w_op;
  assign w_cnt_en  = (r_state == ST_REQ) | (r_state == ST_WAIT);

  dmem_access_ctrl_timeout_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  // Transaction sequencer; completion wins over a coincident timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= {ADDR_W{1'b0}};
      r_wdata    <= {DATA_W{1'b0}};
      r_mem_data <= {DATA_W{1'b0}};
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_op) begin
            r_addr  <= word_align(i_M_ALUout);
            r_wdata <= i_M_WriteData;
            r_we    <= i_M_MemWrite;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.mem_ready) begin
            r_req   <= 1'b0;
            r_state <= r_we ? ST_DONE : ST_WAIT;
          end else if (w_tc) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            if (!r_we) begin
              r_mem_data <= {DATA_W{1'b0}};
            end
            r_state <= ST_DONE;
          end
        end
        ST_WAIT: begin
          if (bus.mem_rvalid) begin
            r_mem_data <= bus.mem_rdata;
            r_state    <= ST_DONE;
          end else if (w_tc) begin
            r_err      <= 1'b1;
            r_mem_data <= {DATA_W{1'b0}};
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Hold in DONE while the pipeline is frozen elsewhere so the op is not reissued.
          if (!i_pipe_hold) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign o_M_MemData   = r_mem_data;
  assign o_mem_err     = r_err;
  // Gated by rst_n so the stall releases the moment reset asserts.
  assign o_mem_stall   = rst_n & w_op & (r_state != ST_DONE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: per-cycle vector table plus hand-written
// sequences for pipe_hold, timeout and reset-during-transaction.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        hold;
    logic        ready;
    logic        rvalid;
    logic [15:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_stall;
    logic [15:0] e_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr, hold;
  logic [15:0] addr, wdata;
  logic [15:0] mdata;
  logic        stall, err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_stall;
  int err_early;

  vec_t vecs[23];

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_M_MemRead   (rd),
    .i_M_MemWrite  (wr),
    .i_M_ALUout    (addr),
    .i_M_WriteData (wdata),
    .i_pipe_hold   (hold),
    .bus           (bus),
    .o_M_MemData   (mdata),
    .o_mem_stall   (stall),
    .o_mem_err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rd    wr    addr      wdata     hold  rdy   rv    rdata       req   we    e_addr    e_wdata   stall e_data
    vecs[0]  = '{1'b1, 1'b0, 16'h0013, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0013, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0013, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000,  1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 16'h0013, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 16'h0013, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 16'h0013, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hBEEF};
    vecs[6]  = '{1'b0, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b0, 1'b1, 16'hDEAD,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
    vecs[7]  = '{1'b0, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000,  1'b1, 1'b1, 16'h0040, 16'h1234, 1'b1, 16'hBEEF};
    vecs[8]  = '{1'b0, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hBEEF};
    vecs[9]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
    vecs[10] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000,  1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'hBEEF};
    vecs[11] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1111,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
    vecs[12] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1111};
    vecs[13] = '{1'b1, 1'b0, 16'h0203, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1111};
    vecs[14] = '{1'b1, 1'b0, 16'h0203, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000,  1'b1, 1'b0, 16'h0202, 16'h0000, 1'b1, 16'h1111};
    vecs[15] = '{1'b1, 1'b0, 16'h0203, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h2222,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1111};
    vecs[16] = '{1'b1, 1'b0, 16'h0203, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h2222};
    vecs[17] = '{1'b0, 1'b0, 16'h1234, 16'h9999, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h2222};
    vecs[18] = '{1'b0, 1'b0, 16'h1234, 16'h9999, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h2222};
    vecs[19] = '{1'b1, 1'b1, 16'h0081, 16'h5A5A, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h2222};
    vecs[20] = '{1'b1, 1'b1, 16'h0081, 16'h5A5A, 1'b0, 1'b1, 1'b0, 16'h0000,  1'b1, 1'b1, 16'h0080, 16'h5A5A, 1'b1, 16'h2222};
    vecs[21] = '{1'b1, 1'b1, 16'h0081, 16'h5A5A, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h2222};
    vecs[22] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000,  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h2222};

    rst_n = 1'b0;
    rd = 1'b0; wr = 1'b0; hold = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 16'h0000;

    #12;
    chk("reset req",   bus.mem_req,   1'b0);
    chk("reset we",    bus.mem_we,    1'b0);
    chk("reset addr",  bus.mem_addr,  16'h0000);
    chk("reset wdata", bus.mem_wdata, 16'h0000);
    chk("reset data",  mdata,         16'h0000);
    chk("reset stall", stall,         1'b0);
    chk("reset err",   err,           1'b0);
    rst_n = 1'b1;
    tick();

    // Load, store, back-to-back loads, ALU ops and read+write as store.
    for (int i = 0; i < 23; i++) begin
      rd = vecs[i].rd; wr = vecs[i].wr; addr = vecs[i].addr; wdata = vecs[i].wdata;
      hold = vecs[i].hold;
      bus.mem_ready = vecs[i].ready; bus.mem_rvalid = vecs[i].rvalid; bus.mem_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d req", i),   bus.mem_req, vecs[i].e_req);
      chk($sformatf("vec%0d stall", i), stall,       vecs[i].e_stall);
      chk($sformatf("vec%0d data", i),  mdata,       vecs[i].e_data);
      chk($sformatf("vec%0d err", i),   err,         1'b0);
      if (vecs[i].e_req) begin
        chk($sformatf("vec%0d we", i),    bus.mem_we,    vecs[i].e_we);
        chk($sformatf("vec%0d addr", i),  bus.mem_addr,  vecs[i].e_addr);
        chk($sformatf("vec%0d wdata", i), bus.mem_wdata, vecs[i].e_wdata);
      end
      tick();
    end
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;

    // Load finishing while pipe_hold is high stays in DONE without reissuing.
    rd = 1'b1; wr = 1'b0; addr = 16'h0300;
    @(negedge clk); chk("hold idle stall", stall, 1'b1);
    tick(); bus.mem_ready = 1'b1;
    @(negedge clk); chk("hold req", bus.mem_req, 1'b1);
    tick(); bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h4444;
    @(negedge clk); chk("hold wait stall", stall, 1'b1);
    tick(); bus.mem_rvalid = 1'b0; hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d req", c),   bus.mem_req, 1'b0);
      chk($sformatf("hold%0d stall", c), stall,       1'b0);
      chk($sformatf("hold%0d data", c),  mdata,       16'h4444);
      tick();
    end
    hold = 1'b0;
    @(negedge clk); chk("hold release stall", stall, 1'b0);
    tick(); rd = 1'b0;
    @(negedge clk);
    chk("after hold req",   bus.mem_req, 1'b0);
    chk("after hold stall", stall,       1'b0);
    chk("after hold data",  mdata,       16'h4444);
    tick();

    // Load accepted but never answered: timeout after 255 REQ/WAIT cycles.
    rd = 1'b1; addr = 16'h0501;
    n_stall = 0; err_early = 0;
    for (int c = 0; c < 300; c++) begin
      bus.mem_ready = (c == 1);
      @(negedge clk);
      if (!stall) break;
      n_stall++;
      if (err) err_early++;
      tick();
    end
    bus.mem_ready = 1'b0;
    chk("timeout stall cycles", n_stall,     256);
    chk("timeout early err",    err_early,   0);
    chk("timeout err",          err,         1'b1);
    chk("timeout data",         mdata,       16'h0000);
    chk("timeout req",          bus.mem_req, 1'b0);
    tick(); rd = 1'b0;
    @(negedge clk); chk("timeout alu err", err, 1'b1);
    tick();

    // A later successful load leaves the error flag set.
    rd = 1'b1; addr = 16'h0610;
    tick(); bus.mem_ready = 1'b1;
    tick(); bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h7777;
    tick(); bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("sticky data", mdata, 16'h7777);
    chk("sticky err",  err,   1'b1);
    tick(); rd = 1'b0;
    tick();

    // Reset while waiting for read data, then a stale rvalid is ignored.
    rd = 1'b1; addr = 16'h0620;
    tick(); bus.mem_ready = 1'b1;
    @(negedge clk); chk("rstwait req", bus.mem_req, 1'b1);
    tick(); bus.mem_ready = 1'b0;
    @(negedge clk); chk("rstwait stall before", stall, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwait req",   bus.mem_req, 1'b0);
    chk("rstwait stall", stall,       1'b0);
    chk("rstwait data",  mdata,       16'h0000);
    chk("rstwait err",   err,         1'b0);
    rd = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hFFFF;
    tick(); tick(); bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stale rvalid data",  mdata,       16'h0000);
    chk("stale rvalid stall", stall,       1'b0);
    chk("stale rvalid req",   bus.mem_req, 1'b0);
    tick();

    // Reset while a request is outstanding drops mem_req immediately.
    rd = 1'b1; addr = 16'h0800;
    tick();
    @(negedge clk); chk("rstreq req before", bus.mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1; chk("rstreq req", bus.mem_req, 1'b0);
    rd = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
